butterfly_pipe: RTL and testbench
=================================

BUTTERFLY_PIPE -- requirements
Module: butterfly_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 16: signed two's-complement width of each real/imag component of A, B, C, D.
REQ-002 SHALL have parameter TW_W, default 16: signed width of each twiddle component.
REQ-003 SHALL have parameter TW_FRAC, default 14: fractional bits of the twiddle (0x4000 = +1.0 at defaults).
REQ-004 SHALL have parameter TAG_W, default 8: width of the pass-through sideband tag.
REQ-005 Ports:
- i_clk  in  1  sole clock, all logic on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  input beat valid.
- o_ready  out  1  block can accept an input beat.
- i_A  in  2*DATA_W  {real[2*DATA_W-1:DATA_W], imag[DATA_W-1:0]}.
- i_B  in  2*DATA_W  same packing as i_A.
- i_W  in  2*TW_W  twiddle, {real, imag}.
- i_inverse  in  1  1 = use conj(W) (inverse transform).
- i_scale  in  1  1 = divide both outputs by 2.
- i_tag  in  TAG_W  sideband carried with the beat.
- o_valid  out  1  output beat valid.
- i_ready  in  1  downstream accepts the output beat.
- o_C  out  2*DATA_W  A + B*W', packed as i_A.
- o_D  out  2*DATA_W  A - B*W', packed as i_A.
- o_tag  out  TAG_W  i_tag of the same beat.
- o_ovf  out  1  sticky saturation flag.
- i_ovf_clr  in  1  clears o_ovf.

Function
REQ-006 SHALL accept a beat when i_valid && o_ready at a rising edge; i_inverse, i_scale and i_tag are sampled with the beat.
REQ-007 SHALL be a 3-stage pipeline. S1 registers the operands. S2 forms four full-precision products Br*Wr', Bi*Wi', Br*Wi', Bi*Wr'. S3 performs the complex sum, add/sub, round, scale and saturate.
REQ-008 SHALL present an accepted beat on o_valid exactly 3 cycles after acceptance when there is no backpressure; throughput is 1 beat/cycle.
REQ-009 Advance enable SHALL be en = !o_valid || i_ready; o_ready SHALL equal en; all stages advance only when en = 1.
REQ-010 Bubbles SHALL propagate as invalid stages and are not collapsed.
REQ-011 While o_valid && !i_ready, o_C, o_D and o_tag SHALL hold stable.
REQ-012 The effective twiddle SHALL be W' = (Wr, Wi) when i_inverse = 0 and W' = (Wr, -Wi) when i_inverse = 1.
REQ-013 Products SHALL be computed at DATA_W+TW_W bits.
REQ-014 P = B*W' SHALL be computed as Pr = Br*Wr' - Bi*Wi' and Pi = Br*Wi' + Bi*Wr', then rounded by adding 2^(TW_FRAC-1) and arithmetic right-shifting by TW_FRAC (round half up).
REQ-015 C = A + P and D = A - P SHALL be formed at DATA_W+2 bits with no intermediate wrap.
REQ-016 When i_scale = 1, each C/D component SHALL become (x + 1) >>> 1 before saturation.
REQ-017 Each output component SHALL saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-018 o_ovf SHALL set on any component saturating in a beat that reaches o_valid, and SHALL hold until i_ovf_clr.
REQ-019 When set and i_ovf_clr coincide in one cycle, set SHALL win.
REQ-020 The Wi = -2^(TW_W-1) corner under inverse SHALL negate at TW_W+1 bits with no wrap.

Reset
REQ-021 On i_rst = 1 at a rising edge, all stage-valid bits, o_valid and o_ovf SHALL become 0.
REQ-022 On reset, o_C, o_D and o_tag SHALL become 0.
REQ-023 o_ready SHALL be 1 in the first cycle after reset.
REQ-024 Reset mid-operation SHALL discard all in-flight beats, and no beat accepted before reset SHALL appear afterwards.
REQ-025 Reset SHALL override i_valid and i_ready in the same cycle.

Verification
REQ-026 Defaults, W = (0x4000, 0), A = (100, 50), B = (20, -10), scale = 0 -> C = (120, 40), D = (80, 60), o_valid 3 cycles after accept.
REQ-027 W = (0, -16384), same A and B. With inverse = 0 -> C = (90, 30), D = (110, 70). With inverse = 1 -> C = (110, 70), D = (90, 30).
REQ-028 A = (32767, 0), B = (32767, 0), W = 1.0. With scale = 0 -> C = (32767, 0) saturated, D = (0, 0), o_ovf = 1. With scale = 1 -> C = (32767, 0), and o_ovf is unchanged by this beat.
REQ-029 Stream 10 beats with tags 0..9 while holding i_ready = 0 for 5 cycles mid-stream. Required: o_ready low during the stall, outputs stable, all 10 tags out in order with none lost or duplicated.
REQ-030 Assert i_rst with 2 beats in flight. Required: o_valid = 0 next cycle, neither beat ever emitted, o_ovf = 0.
REQ-031 Pulse i_ovf_clr in the same cycle as a saturating output. Required: o_ovf remains 1; a later clear with no saturation gives o_ovf = 0.

Source files
------------

// File: rtl/butterfly_pipe.sv
// butterfly_pipe: 3-stage radix-2 butterfly C=A+B*W', D=A-B*W' with round/scale/saturate; ports i_valid/o_ready in, o_valid/i_ready out, i_A/i_B/i_W/i_inverse/i_scale/i_tag -> o_C/o_D/o_tag, sticky o_ovf cleared by i_ovf_clr
module butterfly_pipe #(
  parameter int DATA_W  = 16,
  parameter int TW_W    = 16,
  parameter int TW_FRAC = 14,
  parameter int TAG_W   = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [2*DATA_W-1:0]   i_A,
  input  logic [2*DATA_W-1:0]   i_B,
  input  logic [2*TW_W-1:0]     i_W,
  input  logic                  i_inverse,
  input  logic                  i_scale,
  input  logic [TAG_W-1:0]      i_tag,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [2*DATA_W-1:0]   o_C,
  output logic [2*DATA_W-1:0]   o_D,
  output logic [TAG_W-1:0]      o_tag,
  output logic                  o_ovf,
  input  logic                  i_ovf_clr
);
  localparam int PW = DATA_W + TW_W;
  localparam int SW = PW + 2;
  localparam logic signed [SW-1:0] HALF = (SW'(1) << TW_FRAC) >>> 1;
  localparam logic signed [SW-1:0] SMAX = (SW'(1) << (DATA_W - 1)) - SW'(1);
  localparam logic signed [SW-1:0] SMIN = -(SW'(1) << (DATA_W - 1));

  function automatic logic signed [SW-1:0] rnd(input logic signed [SW-1:0] x);
    return (x + HALF) >>> TW_FRAC;
  endfunction

  function automatic logic signed [SW-1:0] scl(input logic signed [SW-1:0] x, input logic s);
    return s ? (x + SW'(1)) >>> 1 : x;
  endfunction

  function automatic logic ov(input logic signed [SW-1:0] x);
    return (x > SMAX) || (x < SMIN);
  endfunction

  function automatic logic [DATA_W-1:0] sat(input logic signed [SW-1:0] x);
    return x > SMAX ? SMAX[DATA_W-1:0] : x < SMIN ? SMIN[DATA_W-1:0] : x[DATA_W-1:0];
  endfunction

  logic                      w_en;
  logic signed [TW_W:0]      w_wr, w_wi;
  logic                      r1_v, r1_scale;
  logic [TAG_W-1:0]          r1_tag;
  logic signed [DATA_W-1:0]  r1_ar, r1_ai, r1_br, r1_bi;
  logic signed [TW_W:0]      r1_wr, r1_wi;
  logic                      r2_v, r2_scale;
  logic [TAG_W-1:0]          r2_tag;
  logic signed [DATA_W-1:0]  r2_ar, r2_ai;
  logic signed [PW-1:0]      r2_prr, r2_pii, r2_pri, r2_pir;
  logic signed [SW-1:0]      w_qr, w_qi, w_cr, w_ci, w_dr, w_di;
  logic                      w_ovf;
  logic                      r_v, r_ovf;
  logic [2*DATA_W-1:0]       r_c, r_d;
  logic [TAG_W-1:0]          r_tag;

  assign w_en    = !r_v || i_ready;
  assign o_ready = w_en;
  assign o_valid = r_v;
  assign o_C     = r_c;
  assign o_D     = r_d;
  assign o_tag   = r_tag;
  assign o_ovf   = r_ovf;

  // twiddle is widened by one bit so conjugating the most negative Wi cannot wrap
  assign w_wr = {i_W[2*TW_W-1], i_W[2*TW_W-1:TW_W]};
  assign w_wi = {i_W[TW_W-1], i_W[TW_W-1:0]};

  always_comb begin
    w_qr  = rnd(SW'(r2_prr) - SW'(r2_pii));
    w_qi  = rnd(SW'(r2_pri) + SW'(r2_pir));
    w_cr  = scl(SW'(r2_ar) + w_qr, r2_scale);
    w_ci  = scl(SW'(r2_ai) + w_qi, r2_scale);
    w_dr  = scl(SW'(r2_ar) - w_qr, r2_scale);
    w_di  = scl(SW'(r2_ai) - w_qi, r2_scale);
    w_ovf = r2_v && (ov(w_cr) || ov(w_ci) || ov(w_dr) || ov(w_di));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r1_v     <= 1'b0;
      r1_scale <= 1'b0;
      r1_tag   <= '0;
      r1_ar    <= '0;
      r1_ai    <= '0;
      r1_br    <= '0;
      r1_bi    <= '0;
      r1_wr    <= '0;
      r1_wi    <= '0;
      r2_v     <= 1'b0;
      r2_scale <= 1'b0;
      r2_tag   <= '0;
      r2_ar    <= '0;
      r2_ai    <= '0;
      r2_prr   <= '0;
      r2_pii   <= '0;
      r2_pri   <= '0;
      r2_pir   <= '0;
      r_v      <= 1'b0;
      r_c      <= '0;
      r_d      <= '0;
      r_tag    <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_en) begin
        r1_v     <= i_valid;
        r1_scale <= i_scale;
        r1_tag   <= i_tag;
        r1_ar    <= i_A[2*DATA_W-1:DATA_W];
        r1_ai    <= i_A[DATA_W-1:0];
        r1_br    <= i_B[2*DATA_W-1:DATA_W];
        r1_bi    <= i_B[DATA_W-1:0];
        r1_wr    <= w_wr;
        r1_wi    <= i_inverse ? -w_wi : w_wi;
        r2_v     <= r1_v;
        r2_scale <= r1_scale;
        r2_tag   <= r1_tag;
        r2_ar    <= r1_ar;
        r2_ai    <= r1_ai;
        r2_prr   <= PW'(r1_br * r1_wr);
        r2_pii   <= PW'(r1_bi * r1_wi);
        r2_pri   <= PW'(r1_br * r1_wi);
        r2_pir   <= PW'(r1_bi * r1_wr);
        r_v      <= r2_v;
        r_c      <= {sat(w_cr), sat(w_ci)};
        r_d      <= {sat(w_dr), sat(w_di)};
        r_tag    <= r2_tag;
      end
      r_ovf <= (w_en && w_ovf) ? 1'b1 : i_ovf_clr ? 1'b0 : r_ovf;
    end
  end
endmodule

// File: tb/tb_butterfly_pipe.sv
// tb_butterfly_pipe: directed self-checking bench for butterfly_pipe
module tb_butterfly_pipe;
  logic        i_clk = 1'b0;
  logic        i_rst, i_valid, o_ready, i_inverse, i_scale, o_valid, i_ready, o_ovf, i_ovf_clr;
  logic [31:0] i_A, i_B, i_W, o_C, o_D;
  logic [7:0]  i_tag, o_tag;
  int          n_cmp = 0;
  int          n_bad = 0;

  butterfly_pipe dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_A(i_A), .i_B(i_B), .i_W(i_W), .i_inverse(i_inverse), .i_scale(i_scale),
    .i_tag(i_tag), .o_valid(o_valid), .i_ready(i_ready), .o_C(o_C), .o_D(o_D),
    .o_tag(o_tag), .o_ovf(o_ovf), .i_ovf_clr(i_ovf_clr)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] pk(input int r, input int i);
    return {r[15:0], i[15:0]};
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_cd(input string tag, input int cr, input int ci, input int dr, input int di);
    chk({tag, ".Cr"}, $signed(o_C[31:16]), cr);
    chk({tag, ".Ci"}, $signed(o_C[15:0]), ci);
    chk({tag, ".Dr"}, $signed(o_D[31:16]), dr);
    chk({tag, ".Di"}, $signed(o_D[15:0]), di);
  endtask

  task automatic drive(input int ar, input int ai, input int br, input int bi,
                       input int wr, input int wi, input logic inv, input logic sc, input int tag);
    i_A = pk(ar, ai);
    i_B = pk(br, bi);
    i_W = pk(wr, wi);
    i_inverse = inv;
    i_scale = sc;
    i_tag = tag[7:0];
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input int ar, input int ai, input int br, input int bi,
                      input int wr, input int wi, input logic inv, input logic sc, input int tag);
    drive(ar, ai, br, bi, wr, wi, inv, sc, tag);
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int k = 0;
    while (!o_valid && k < 8) begin
      tick();
      k++;
    end
    chk({tag, ".valid"}, o_valid, 1);
  endtask

  initial begin
    int sent, got, seen;
    logic [31:0] h_c, h_d;
    logic [7:0]  h_t;
    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_ovf_clr = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 0);
    tick();
    tick();
    i_rst = 1'b0;
    chk("rst.ready", o_ready, 1);
    chk("rst.valid", o_valid, 0);
    chk("rst.ovf", o_ovf, 0);
    chk("rst.tag", o_tag, 0);
    chk_cd("rst", 0, 0, 0, 0);

    send(100, 50, 20, -10, 16384, 0, 1'b0, 1'b0, 8'h11);
    chk("lat.e1", o_valid, 0);
    tick();
    chk("lat.e2", o_valid, 0);
    tick();
    chk("lat.e3", o_valid, 1);
    chk("lat.tag", o_tag, 8'h11);
    chk_cd("unity", 120, 40, 80, 60);

    send(100, 50, 20, -10, 0, -16384, 1'b0, 1'b0, 2);
    wait_out("fwd");
    chk_cd("fwd", 90, 30, 110, 70);
    send(100, 50, 20, -10, 0, -16384, 1'b1, 1'b0, 3);
    wait_out("inv");
    chk_cd("inv", 110, 70, 90, 30);

    send(0, 0, 1, 0, 8192, 0, 1'b0, 1'b0, 4);
    wait_out("rnd_pos");
    chk_cd("rnd_pos", 1, 0, -1, 0);
    send(0, 0, -1, 0, 8192, 0, 1'b0, 1'b0, 5);
    wait_out("rnd_neg");
    chk_cd("rnd_neg", 0, 0, 0, 0);
    send(3, -3, 0, 0, 16384, 0, 1'b0, 1'b1, 6);
    wait_out("scl_rnd");
    chk_cd("scl_rnd", 2, -1, 2, -1);
    send(0, 0, 0, 100, 0, -32768, 1'b1, 1'b0, 7);
    wait_out("wi_min");
    chk_cd("wi_min", -200, 0, 200, 0);
    chk("pre_sat.ovf", o_ovf, 0);

    send(32767, 0, 32767, 0, 16384, 0, 1'b0, 1'b0, 8);
    wait_out("sat");
    chk_cd("sat", 32767, 0, 0, 0);
    chk("sat.ovf", o_ovf, 1);
    i_ovf_clr = 1'b1;
    tick();
    i_ovf_clr = 1'b0;
    chk("clr.ovf", o_ovf, 0);
    send(32767, 0, 32767, 0, 16384, 0, 1'b0, 1'b1, 9);
    wait_out("sat_scl");
    chk_cd("sat_scl", 32767, 0, 0, 0);
    chk("sat_scl.ovf", o_ovf, 0);

    i_ovf_clr = 1'b1;
    send(-32768, 0, 32767, 0, 16384, 0, 1'b0, 1'b0, 10);
    wait_out("setwin");
    chk_cd("setwin", -1, 0, -32768, 0);
    chk("setwin.ovf", o_ovf, 1);
    tick();
    i_ovf_clr = 1'b0;
    chk("laterclr.ovf", o_ovf, 0);

    sent = 0;
    got = 0;
    h_c = '0; h_d = '0; h_t = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      i_ready = !(cyc >= 6 && cyc < 11);
      i_valid = (sent < 10);
      drive(10 * sent, -sent, sent, 2, 16384, 0, 1'b0, 1'b0, sent);
      #1;
      if (cyc == 6) begin
        h_c = o_C; h_d = o_D; h_t = o_tag;
      end
      if (cyc >= 6 && cyc < 11) begin
        chk("stall.ready", o_ready, 0);
        if (cyc > 6) begin
          chk("stall.C", o_C, h_c);
          chk("stall.D", o_D, h_d);
          chk("stall.tag", o_tag, h_t);
        end
      end
      if (o_valid && i_ready) begin
        chk("strm.tag", o_tag, got);
        chk_cd("strm", 11 * got, 2 - got, 9 * got, -got - 2);
        got++;
      end
      if (i_valid && o_ready) sent++;
      @(posedge i_clk);
      #1;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    chk("strm.count", got, 10);

    send(32767, 0, 32767, 0, 16384, 0, 1'b0, 1'b0, 20);
    wait_out("pre_rst");
    chk("pre_rst.ovf", o_ovf, 1);
    drive(1, 1, 1, 1, 16384, 0, 1'b0, 1'b0, 21);
    i_valid = 1'b1;
    tick();
    drive(2, 2, 2, 2, 16384, 0, 1'b0, 1'b0, 22);
    tick();
    i_rst = 1'b1;
    i_ready = 1'b0;
    tick();
    i_rst = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    chk("mid_rst.valid", o_valid, 0);
    chk("mid_rst.ovf", o_ovf, 0);
    chk("mid_rst.ready", o_ready, 1);
    chk_cd("mid_rst", 0, 0, 0, 0);
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (o_valid) seen++;
    end
    chk("mid_rst.ghost", seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
